// File: rtl/johnson_sequence_controller_if.sv
// Command and status bundle for the Johnson sequence controller.
// Handshake: commands and Step_Tick_In are single-cycle level strobes sampled on
// every rising clock edge; there is no ready/valid back-pressure. A command is
// acted on in the cycle it is sampled high, subject to Stop > Pause > Start priority.
interface johnson_sequence_controller_if #(
    parameter int WIDTH      = 16,
    parameter int LOOP_WIDTH = 8,
    parameter int IDX_WIDTH  = 5
);
    logic                  Start_Command_In;
    logic                  Pause_Command_In;
    logic                  Stop_Command_In;
    logic                  Step_Tick_In;
    logic [LOOP_WIDTH-1:0] Loop_Count_In;
    logic                  Busy_Out;
    logic                  Paused_Out;
    logic                  Done_Pulse_Out;
    logic [WIDTH-1:0]      Phase_Out;
    logic [IDX_WIDTH-1:0]  Phase_Index_Out;
    logic [LOOP_WIDTH-1:0] Loops_Remaining_Out;
    logic [1:0]            State_Dbg_Out;

    // Command source (bench or upstream sequencer)
    modport master (
        output Start_Command_In, Pause_Command_In, Stop_Command_In,
        output Step_Tick_In, Loop_Count_In,
        input  Busy_Out, Paused_Out, Done_Pulse_Out, Phase_Out,
        input  Phase_Index_Out, Loops_Remaining_Out, State_Dbg_Out
    );

    // The controller itself
    modport slave (
        input  Start_Command_In, Pause_Command_In, Stop_Command_In,
        input  Step_Tick_In, Loop_Count_In,
        output Busy_Out, Paused_Out, Done_Pulse_Out, Phase_Out,
        output Phase_Index_Out, Loops_Remaining_Out, State_Dbg_Out
    );
endinterface

// File: rtl/johnson_sequence_controller.sv
// Johnson sequence controller: steps a WIDTH-bit Johnson register through a
// programmed number of 2*WIDTH-step loops (0 = endless), with start/resume,
// pause and stop commands and a one-cycle done pulse after the last loop.
module johnson_sequence_controller #(
    parameter int WIDTH      = 16,
    parameter int LOOP_WIDTH = 8,
    parameter int IDX_WIDTH  = 5
) (
    input  logic Clk_In,
    input  logic Reset_In,
    johnson_sequence_controller_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(2 * WIDTH - 1);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      phase_q, phase_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [LOOP_WIDTH-1:0] loops_q, loops_d;
    logic                  infinite_q, infinite_d;

    logic start_cmd, pause_cmd, stop_cmd, tick;
    assign start_cmd = bus.Start_Command_In;
    assign pause_cmd = bus.Pause_Command_In;
    assign stop_cmd  = bus.Stop_Command_In;
    assign tick      = bus.Step_Tick_In;

    // Next-state and datapath: one Johnson step per tick in RUN, loop accounting at wrap
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        idx_d      = idx_q;
        loops_d    = loops_q;
        infinite_d = infinite_q;
        case (state_q)
            ST_IDLE: begin
                // Pause outranks Start, so a coincident Pause keeps us idle
                if (start_cmd && !stop_cmd && !pause_cmd) begin
                    state_d    = ST_RUN;
                    loops_d    = bus.Loop_Count_In;
                    infinite_d = (bus.Loop_Count_In == '0);
                end
            end
            ST_RUN: begin
                if (stop_cmd) begin
                    state_d    = ST_IDLE;
                    phase_d    = '0;
                    idx_d      = '0;
                    loops_d    = '0;
                    infinite_d = 1'b0;
                end else if (pause_cmd) begin
                    state_d = ST_PAUSED;
                end else if (tick) begin
                    phase_d = {phase_q[WIDTH-2:0], ~phase_q[WIDTH-1]};
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (!infinite_q) begin
                            loops_d = loops_q - LOOP_WIDTH'(1);
                            if (loops_q == LOOP_WIDTH'(1)) begin
                                state_d = ST_DONE;
                            end
                        end
                    end else begin
                        idx_d = idx_q + IDX_WIDTH'(1);
                    end
                end
            end
            ST_PAUSED: begin
                if (stop_cmd) begin
                    state_d    = ST_IDLE;
                    phase_d    = '0;
                    idx_d      = '0;
                    loops_d    = '0;
                    infinite_d = 1'b0;
                end else if (start_cmd && !pause_cmd) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                infinite_d = 1'b0;
            end
            default: begin
                state_d    = ST_IDLE;
                phase_d    = '0;
                idx_d      = '0;
                loops_d    = '0;
                infinite_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            idx_q      <= '0;
            loops_q    <= '0;
            infinite_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            loops_q    <= loops_d;
            infinite_q <= infinite_d;
        end
    end

    // Status flags are pure decodes of the registered state
    assign bus.Busy_Out            = (state_q == ST_RUN) || (state_q == ST_PAUSED);
    assign bus.Paused_Out          = (state_q == ST_PAUSED);
    assign bus.Done_Pulse_Out      = (state_q == ST_DONE);
    assign bus.Phase_Out           = phase_q;
    assign bus.Phase_Index_Out     = idx_q;
    assign bus.Loops_Remaining_Out = loops_q;
    assign bus.State_Dbg_Out       = state_q;
endmodule

// File: tb/tb_johnson_sequence_controller.sv
// Directed bench for the Johnson sequence controller at WIDTH=4.
module tb_johnson_sequence_controller;
    localparam int WIDTH      = 4;
    localparam int LOOP_WIDTH = 8;
    localparam int IDX_WIDTH  = 3;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   done_seen;

    // Phase value after k ticks from zero is seq[(k-1) % 8]
    logic [3:0] seq [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

    johnson_sequence_controller_if #(
        .WIDTH(WIDTH), .LOOP_WIDTH(LOOP_WIDTH), .IDX_WIDTH(IDX_WIDTH)
    ) bus ();

    johnson_sequence_controller #(
        .WIDTH(WIDTH), .LOOP_WIDTH(LOOP_WIDTH), .IDX_WIDTH(IDX_WIDTH)
    ) dut (
        .Clk_In   (clk),
        .Reset_In (rst),
        .bus      (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of commands, then sample #1 after the edge
    task automatic cycle(input logic s, input logic p, input logic st, input logic t);
        bus.Start_Command_In = s;
        bus.Pause_Command_In = p;
        bus.Stop_Command_In  = st;
        bus.Step_Tick_In     = t;
        @(posedge clk);
        #1;
        bus.Start_Command_In = 1'b0;
        bus.Pause_Command_In = 1'b0;
        bus.Stop_Command_In  = 1'b0;
        bus.Step_Tick_In     = 1'b0;
        if (bus.Done_Pulse_Out) done_seen++;
    endtask

    task automatic start_run(input logic [LOOP_WIDTH-1:0] n);
        bus.Loop_Count_In = n;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, 32'(bus.State_Dbg_Out), 32'(S_IDLE));
        check({tag, "_busy"},  32'(bus.Busy_Out), 0);
        check({tag, "_phase"}, 32'(bus.Phase_Out), 0);
        check({tag, "_idx"},   32'(bus.Phase_Index_Out), 0);
        check({tag, "_loops"}, 32'(bus.Loops_Remaining_Out), 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        done_seen = 0;
        bus.Start_Command_In = 1'b0;
        bus.Pause_Command_In = 1'b0;
        bus.Stop_Command_In  = 1'b0;
        bus.Step_Tick_In     = 1'b0;
        bus.Loop_Count_In    = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("por");
        check("por_done", 32'(bus.Done_Pulse_Out), 0);
        rst = 1'b0;

        // Reset mid-run aborts without a done pulse
        start_run(8'd2);
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_pre_phase", 32'(bus.Phase_Out), 32'h E);
        rst = 1'b1;
        done_seen = 0;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        check_idle("rst");
        check("rst_paused", 32'(bus.Paused_Out), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_idle("rst_after");
        check("rst_no_done", 32'(done_seen), 0);

        // Two full loops with a tick every cycle
        start_run(8'd2);
        check("two_busy", 32'(bus.Busy_Out), 1);
        check("two_loops0", 32'(bus.Loops_Remaining_Out), 2);
        done_seen = 0;
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            check($sformatf("two_phase%0d", k), 32'(bus.Phase_Out), 32'(seq[(k - 1) % 8]));
            check($sformatf("two_idx%0d", k), 32'(bus.Phase_Index_Out), 32'(k % 8));
            if (k == 8) check("two_loops1", 32'(bus.Loops_Remaining_Out), 1);
        end
        check("two_done", 32'(bus.Done_Pulse_Out), 1);
        check("two_done_busy", 32'(bus.Busy_Out), 0);
        check("two_loops_end", 32'(bus.Loops_Remaining_Out), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("two_done_gone", 32'(bus.Done_Pulse_Out), 0);
        check_idle("two_after");
        check("two_done_count", 32'(done_seen), 1);

        // Pause after three steps, ticks ignored, then resume
        start_run(8'd1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("pause_flag", 32'(bus.Paused_Out), 1);
        check("pause_busy", 32'(bus.Busy_Out), 1);
        repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("pause_phase", 32'(bus.Phase_Out), 32'h7);
        check("pause_idx", 32'(bus.Phase_Index_Out), 3);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("resume_state", 32'(bus.State_Dbg_Out), 32'(S_RUN));
        check("resume_phase", 32'(bus.Phase_Out), 32'h7);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("resume_phase7", 32'(bus.Phase_Out), 32'h8);
        check("resume_busy7", 32'(bus.Busy_Out), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("resume_done", 32'(bus.Done_Pulse_Out), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Simultaneous commands
        bus.Loop_Count_In = 8'd3;
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("sim_startstop_state", 32'(bus.State_Dbg_Out), 32'(S_IDLE));
        start_run(8'd3);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("sim_step1", 32'(bus.Phase_Out), 32'h1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("sim_pausetick_state", 32'(bus.State_Dbg_Out), 32'(S_PAUSED));
        check("sim_pausetick_phase", 32'(bus.Phase_Out), 32'h1);
        check("sim_pausetick_idx", 32'(bus.Phase_Index_Out), 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("sim_step2", 32'(bus.Phase_Out), 32'h3);
        done_seen = 0;
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        check_idle("sim_stoppause");
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("sim_no_done", 32'(done_seen), 0);

        // Endless mode
        start_run(8'd0);
        done_seen = 0;
        repeat (100) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("inf_no_done", 32'(done_seen), 0);
        check("inf_loops", 32'(bus.Loops_Remaining_Out), 0);
        check("inf_idx", 32'(bus.Phase_Index_Out), 4);
        check("inf_phase", 32'(bus.Phase_Out), 32'hF);
        check("inf_busy", 32'(bus.Busy_Out), 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check_idle("inf_stop");

        // Start in RUN does not re-latch the loop count
        start_run(8'd1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        bus.Loop_Count_In = 8'd5;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("relatch_loops", 32'(bus.Loops_Remaining_Out), 1);
        check("relatch_phase", 32'(bus.Phase_Out), 32'h3);
        done_seen = 0;
        repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("relatch_done", 32'(bus.Done_Pulse_Out), 1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("relatch_done_once", 32'(done_seen), 1);
        check_idle("relatch_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
